execute_stage: RTL and testbench

Parametrised execute pipeline stage for the RISC-V core.
- Resolves operand forwarding from MEM and WB and selects rs2 or the immediate.
- Computes single-cycle ALU results and runs multi-cycle RV32M/RV64M multiply/divide through an iterative sub-unit.
- Registers results into a valid/ready EX/MEM output slot.
- Sits between decode (ID/EX) and memory access. Adds backpressure, flush and M-extension behaviour that the previous execute stage lacked.

---
 rtl/exec_pkg.sv | 43 ++++
 rtl/execute_stage_muldiv.sv | 134 +++++++++++++
 rtl/execute_stage.sv | 166 ++++++++++++++++
 tb/tb_execute_stage.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/exec_pkg.sv
// Shared types and helpers for the execute stage and its multiply/divide unit.
package exec_pkg;

  // Operation codes driven by decode. M-extension ops occupy 16..23.
  typedef enum logic [4:0] {
    OP_ADD    = 5'd0,
    OP_SUB    = 5'd1,
    OP_AND    = 5'd2,
    OP_OR     = 5'd3,
    OP_XOR    = 5'd4,
    OP_SLL    = 5'd5,
    OP_SRL    = 5'd6,
    OP_SRA    = 5'd7,
    OP_SLT    = 5'd8,
    OP_SLTU   = 5'd9,
    OP_PASS_B = 5'd10,
    OP_MUL    = 5'd16,
    OP_MULH   = 5'd17,
    OP_MULHSU = 5'd18,
    OP_MULHU  = 5'd19,
    OP_DIV    = 5'd20,
    OP_DIVU   = 5'd21,
    OP_REM    = 5'd22,
    OP_REMU   = 5'd23
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } muldiv_state_e;

  // Widest supported datapath; narrower corner constants are sliced from these.
  localparam int unsigned XLEN_MAX = 64;
  localparam logic [XLEN_MAX-1:0] DIV_ZERO_QUOT_MAX = '1;
  localparam logic [XLEN_MAX-1:0] DIV_MIN_NEG_TOP   = {1'b1, {(XLEN_MAX-1){1'b0}}};

  // M-extension ops are exactly the codes 16..23.
  function automatic logic is_muldiv(input logic [4:0] op);
    return (op[4:3] == 2'b10);
  endfunction

endpackage

// File: rtl/execute_stage_muldiv.sv
// Iterative RV32M/RV64M unit: shift-add multiplier and restoring divider on
// magnitudes, with sign and corner-case correction applied in DONE.
module muldiv_unit
  import exec_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            start,
  input  alu_op_e         op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            slot_free,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CNT_W = $clog2(XLEN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);
  localparam logic [XLEN-1:0] DIV_ZERO_QUOT = DIV_ZERO_QUOT_MAX[XLEN-1:0];
  localparam logic [XLEN-1:0] DIV_MIN_NEG   = DIV_MIN_NEG_TOP[XLEN_MAX-1 -: XLEN];

  muldiv_state_e state, state_nxt;
  logic [CNT_W-1:0] cnt;

  logic [XLEN-1:0] mcand, acc, lo, a_orig;
  logic            is_div, want_rem, want_hi, neg_res, div_zero, div_ovf;

  logic            a_signed, b_signed, a_neg, b_neg, op_div, op_rem, op_hi;
  logic [XLEN-1:0] a_abs, b_abs;

  logic [XLEN:0]   mul_sum, rem_sh;
  logic [XLEN+1:0] diff;

  logic [2*XLEN-1:0] prod, prod_fix;
  logic [XLEN-1:0]   qr, qr_fix;

  // Start-time operand decode: which operands are signed and their magnitudes.
  always_comb begin
    a_signed = op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
    b_signed = op inside {OP_MULH, OP_DIV, OP_REM};
    op_div   = op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
    op_rem   = op inside {OP_REM, OP_REMU};
    op_hi    = op inside {OP_MULH, OP_MULHSU, OP_MULHU};
    a_neg    = a_signed && a[XLEN-1];
    b_neg    = b_signed && b[XLEN-1];
    a_abs    = a_neg ? (~a + 1'b1) : a;
    b_abs    = b_neg ? (~b + 1'b1) : b;
  end

  // One iteration of either algorithm; only the one selected by is_div is used.
  always_comb begin
    mul_sum = {1'b0, acc} + {1'b0, (lo[0] ? mcand : {XLEN{1'b0}})};
    rem_sh  = {acc, lo[XLEN-1]};
    diff    = {1'b0, rem_sh} - {2'b00, mcand};
  end

  // State register; flush and reset both abandon the operation.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next state: XLEN RUN cycles, then DONE until the output slot can take it.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (cnt == CNT_LAST) state_nxt = DONE;
      DONE:    if (slot_free) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (flush) state_nxt = IDLE;
  end

  // Iteration counter runs 0..XLEN-1 during RUN.
  always_ff @(posedge clk) begin
    if (rst)                cnt <= '0;
    else if (state != RUN)  cnt <= '0;
    else                    cnt <= cnt + 1'b1;
  end

  // Operand capture on start, then one multiply or divide step per RUN cycle.
  always_ff @(posedge clk) begin
    if (state == IDLE && start) begin
      mcand    <= op_div ? b_abs : a_abs;
      lo       <= op_div ? a_abs : b_abs;
      acc      <= '0;
      a_orig   <= a;
      is_div   <= op_div;
      want_rem <= op_rem;
      want_hi  <= op_hi;
      neg_res  <= op_rem ? a_neg : (a_neg ^ b_neg);
      div_zero <= (b == '0);
      div_ovf  <= a_signed && (a == DIV_MIN_NEG) && (b == '1);
    end else if (state == RUN) begin
      if (is_div) begin
        if (!diff[XLEN+1]) begin
          acc <= diff[XLEN-1:0];
          lo  <= {lo[XLEN-2:0], 1'b1};
        end else begin
          acc <= rem_sh[XLEN-1:0];
          lo  <= {lo[XLEN-2:0], 1'b0};
        end
      end else begin
        acc <= mul_sum[XLEN:1];
        lo  <= {mul_sum[0], lo[XLEN-1:1]};
      end
    end
  end

  // Sign correction and division corner cases, presented while in DONE.
  always_comb begin
    prod     = {acc, lo};
    prod_fix = neg_res ? (~prod + 1'b1) : prod;
    qr       = want_rem ? acc : lo;
    qr_fix   = neg_res ? (~qr + 1'b1) : qr;
    result   = '0;
    if (is_div) begin
      if (div_zero)     result = want_rem ? a_orig : DIV_ZERO_QUOT;
      else if (div_ovf) result = want_rem ? '0 : a_orig;
      else              result = qr_fix;
    end else begin
      result = want_hi ? prod_fix[2*XLEN-1:XLEN] : prod_fix[XLEN-1:0];
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE) && slot_free;

endmodule

// File: rtl/execute_stage.sv
// Execute stage: operand forwarding, single-cycle ALU, iterative muldiv and a
// valid/ready EX/MEM output slot with flush.
module execute_stage
  import exec_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5,
  parameter bit MULDIV_EN  = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4:0]            in_op,
  input  logic [REG_ADDR_W-1:0] in_rs1_addr,
  input  logic [REG_ADDR_W-1:0] in_rs2_addr,
  input  logic [XLEN-1:0]       in_rs1_data,
  input  logic [XLEN-1:0]       in_rs2_data,
  input  logic [XLEN-1:0]       in_imm,
  input  logic                  in_alu_src,
  input  logic [REG_ADDR_W-1:0] in_rd_addr,
  input  logic                  in_reg_write,
  input  logic                  in_mem_read,
  input  logic                  in_mem_write,
  input  logic                  fwd_mem_valid,
  input  logic                  fwd_wb_valid,
  input  logic [REG_ADDR_W-1:0] fwd_mem_rd,
  input  logic [REG_ADDR_W-1:0] fwd_wb_rd,
  input  logic [XLEN-1:0]       fwd_mem_data,
  input  logic [XLEN-1:0]       fwd_wb_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [XLEN-1:0]       out_result,
  output logic [XLEN-1:0]       out_store_data,
  output logic [REG_ADDR_W-1:0] out_rd_addr,
  output logic                  out_reg_write,
  output logic                  out_mem_read,
  output logic                  out_mem_write,
  output logic                  busy
);

  localparam int SHW = $clog2(XLEN);

  alu_op_e                op_p0;
  logic [XLEN-1:0]        rs1_p0, rs2_p0, op2_p0, alu_p0;
  logic signed [XLEN-1:0] rs1_s_p0, op2_s_p0;
  logic [SHW-1:0]         shamt_p0;
  logic                   accept, is_md_p0, md_start, alu_load, slot_free;
  logic                   md_busy, md_done;
  logic [XLEN-1:0]        md_result;

  logic [REG_ADDR_W-1:0]  pend_rd;
  logic                   pend_reg_write, pend_mem_read, pend_mem_write;
  logic [XLEN-1:0]        pend_store;

  assign op_p0 = alu_op_e'(in_op);

  // Operand forwarding: MEM beats WB, register x0 is never forwarded.
  always_comb begin
    rs1_p0 = in_rs1_data;
    if (in_rs1_addr != '0) begin
      if (fwd_mem_valid && fwd_mem_rd == in_rs1_addr)     rs1_p0 = fwd_mem_data;
      else if (fwd_wb_valid && fwd_wb_rd == in_rs1_addr)  rs1_p0 = fwd_wb_data;
    end
    rs2_p0 = in_rs2_data;
    if (in_rs2_addr != '0) begin
      if (fwd_mem_valid && fwd_mem_rd == in_rs2_addr)     rs2_p0 = fwd_mem_data;
      else if (fwd_wb_valid && fwd_wb_rd == in_rs2_addr)  rs2_p0 = fwd_wb_data;
    end
    op2_p0 = in_alu_src ? in_imm : rs2_p0;
  end

  assign rs1_s_p0 = rs1_p0;
  assign op2_s_p0 = op2_p0;
  assign shamt_p0 = op2_p0[SHW-1:0];

  // Single-cycle ALU; M ops and undefined codes produce 0 here.
  always_comb begin
    alu_p0 = '0;
    case (op_p0)
      OP_ADD:    alu_p0 = rs1_p0 + op2_p0;
      OP_SUB:    alu_p0 = rs1_p0 - op2_p0;
      OP_AND:    alu_p0 = rs1_p0 & op2_p0;
      OP_OR:     alu_p0 = rs1_p0 | op2_p0;
      OP_XOR:    alu_p0 = rs1_p0 ^ op2_p0;
      OP_SLL:    alu_p0 = rs1_p0 << shamt_p0;
      OP_SRL:    alu_p0 = rs1_p0 >> shamt_p0;
      OP_SRA:    alu_p0 = rs1_s_p0 >>> shamt_p0;
      OP_SLT:    alu_p0 = {{(XLEN-1){1'b0}}, (rs1_s_p0 < op2_s_p0)};
      OP_SLTU:   alu_p0 = {{(XLEN-1){1'b0}}, (rs1_p0 < op2_p0)};
      OP_PASS_B: alu_p0 = op2_p0;
      default:   alu_p0 = '0;
    endcase
  end

  assign slot_free = !out_valid || out_ready;
  assign in_ready  = !rst && !flush && !md_busy && slot_free;
  assign accept    = in_valid && in_ready;
  assign is_md_p0  = MULDIV_EN && is_muldiv(in_op);
  assign md_start  = accept && is_md_p0;
  assign alu_load  = accept && !is_md_p0;
  assign busy      = md_busy;

  muldiv_unit #(.XLEN(XLEN)) u_muldiv (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .start     (md_start),
    .op        (op_p0),
    .a         (rs1_p0),
    .b         (op2_p0),
    .slot_free (slot_free),
    .busy      (md_busy),
    .done      (md_done),
    .result    (md_result)
  );

  // ---- p0 -> p1: control and store data of a muldiv op wait here until DONE
  always_ff @(posedge clk) begin
    if (md_start) begin
      pend_rd        <= in_rd_addr;
      pend_reg_write <= in_reg_write;
      pend_mem_read  <= in_mem_read;
      pend_mem_write <= in_mem_write;
      pend_store     <= rs2_p0;
    end
  end

  // ---- p1: EX/MEM output slot; flush kills it, consume and reload may overlap
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid      <= 1'b0;
      out_result     <= '0;
      out_store_data <= '0;
      out_rd_addr    <= '0;
      out_reg_write  <= 1'b0;
      out_mem_read   <= 1'b0;
      out_mem_write  <= 1'b0;
    end else if (flush) begin
      out_valid      <= 1'b0;
      out_reg_write  <= 1'b0;
      out_mem_read   <= 1'b0;
      out_mem_write  <= 1'b0;
    end else if (alu_load) begin
      out_valid      <= 1'b1;
      out_result     <= alu_p0;
      out_store_data <= rs2_p0;
      out_rd_addr    <= in_rd_addr;
      out_reg_write  <= in_reg_write;
      out_mem_read   <= in_mem_read;
      out_mem_write  <= in_mem_write;
    end else if (md_done) begin
      out_valid      <= 1'b1;
      out_result     <= md_result;
      out_store_data <= pend_store;
      out_rd_addr    <= pend_rd;
      out_reg_write  <= pend_reg_write;
      out_mem_read   <= pend_mem_read;
      out_mem_write  <= pend_mem_write;
    end else if (out_ready) begin
      out_valid      <= 1'b0;
    end
  end

endmodule

// File: tb/tb_execute_stage.sv
// Directed bench for execute_stage with hand-computed expected values.
module tb_execute_stage;

  localparam logic [4:0] ADD = 5'd0, SUB = 5'd1, AND_ = 5'd2, OR_ = 5'd3, XOR_ = 5'd4;
  localparam logic [4:0] SLL = 5'd5, SRL = 5'd6, SRA = 5'd7, SLT = 5'd8, SLTU = 5'd9;
  localparam logic [4:0] PASSB = 5'd10, MUL = 5'd16, MULH = 5'd17, MULHSU = 5'd18;
  localparam logic [4:0] MULHU = 5'd19, DIV = 5'd20, DIVU = 5'd21, REM = 5'd22, REMU = 5'd23;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, in_alu_src;
  logic [4:0]  in_op, in_rs1_addr, in_rs2_addr, in_rd_addr;
  logic [31:0] in_rs1_data, in_rs2_data, in_imm;
  logic        in_reg_write, in_mem_read, in_mem_write;
  logic        fwd_mem_valid, fwd_wb_valid;
  logic [4:0]  fwd_mem_rd, fwd_wb_rd;
  logic [31:0] fwd_mem_data, fwd_wb_data;
  logic        out_valid, out_ready, out_reg_write, out_mem_read, out_mem_write, busy;
  logic [31:0] out_result, out_store_data;
  logic [4:0]  out_rd_addr;

  int vectors = 0;
  int miscompares = 0;

  execute_stage #(.XLEN(32), .REG_ADDR_W(5), .MULDIV_EN(1'b1)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_rs1_addr(in_rs1_addr), .in_rs2_addr(in_rs2_addr),
    .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data), .in_imm(in_imm),
    .in_alu_src(in_alu_src), .in_rd_addr(in_rd_addr), .in_reg_write(in_reg_write),
    .in_mem_read(in_mem_read), .in_mem_write(in_mem_write),
    .fwd_mem_valid(fwd_mem_valid), .fwd_wb_valid(fwd_wb_valid),
    .fwd_mem_rd(fwd_mem_rd), .fwd_wb_rd(fwd_wb_rd),
    .fwd_mem_data(fwd_mem_data), .fwd_wb_data(fwd_wb_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_store_data(out_store_data), .out_rd_addr(out_rd_addr),
    .out_reg_write(out_reg_write), .out_mem_read(out_mem_read),
    .out_mem_write(out_mem_write), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic [4:0] op, input logic [4:0] r1a, input logic [31:0] r1d,
                        input logic [4:0] r2a, input logic [31:0] r2d, input logic [31:0] imm,
                        input logic src, input logic [4:0] rd);
    in_op = op; in_rs1_addr = r1a; in_rs1_data = r1d; in_rs2_addr = r2a; in_rs2_data = r2d;
    in_imm = imm; in_alu_src = src; in_rd_addr = rd;
    in_reg_write = 1'b1; in_mem_read = 1'b0; in_mem_write = 1'b0;
  endtask

  // Accept one muldiv op and wait (bounded) for its result.
  task automatic run_md(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output int busy_cnt, output logic [31:0] res);
    set_op(op, 5'd1, a, 5'd2, b, 32'd0, 1'b0, 5'd9);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 1; busy_cnt = 0;
    while (out_valid !== 1'b1 && lat < 100) begin
      if (busy === 1'b1) busy_cnt++;
      tick();
      lat++;
    end
    res = out_result;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(); tick();
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", busy); end
    vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL reset_in_ready got %b want 0", in_ready); end
    vectors++; if (out_result !== 32'd0 || out_rd_addr !== 5'd0 || out_reg_write !== 1'b0) begin
      miscompares++; $display("FAIL reset_fields got %h/%h/%b want 0/0/0", out_result, out_rd_addr, out_reg_write); end
    rst = 1'b0;
    #1;
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_release_ready got %b want 1", in_ready); end
  endtask

  task automatic test_forward();
    fwd_mem_valid = 1'b1; fwd_mem_rd = 5'd5; fwd_mem_data = 32'h11;
    fwd_wb_valid = 1'b1;  fwd_wb_rd = 5'd5;  fwd_wb_data = 32'h22;
    set_op(ADD, 5'd5, 32'h99, 5'd0, 32'd0, 32'd1, 1'b1, 5'd7);
    in_valid = 1'b1;
    tick(); in_valid = 1'b0;
    vectors++; if (out_valid !== 1'b1 || out_result !== 32'h12) begin miscompares++; $display("FAIL fwd_mem_prio got %b/%h want 1/00000012", out_valid, out_result); end
    vectors++; if (out_rd_addr !== 5'd7) begin miscompares++; $display("FAIL fwd_rd got %h want 07", out_rd_addr); end
    fwd_mem_valid = 1'b0;
    in_valid = 1'b1; tick(); in_valid = 1'b0;
    vectors++; if (out_result !== 32'h23) begin miscompares++; $display("FAIL fwd_wb got %h want 00000023", out_result); end
    fwd_mem_valid = 1'b1; fwd_mem_rd = 5'd0; fwd_wb_rd = 5'd0;
    set_op(ADD, 5'd0, 32'd7, 5'd0, 32'd0, 32'd1, 1'b1, 5'd7);
    in_valid = 1'b1; tick(); in_valid = 1'b0;
    vectors++; if (out_result !== 32'h8) begin miscompares++; $display("FAIL fwd_x0 got %h want 00000008", out_result); end
    fwd_mem_valid = 1'b0; fwd_wb_valid = 1'b1; fwd_wb_rd = 5'd3; fwd_wb_data = 32'h5;
    set_op(SUB, 5'd1, 32'h10, 5'd3, 32'h77, 32'd0, 1'b0, 5'd2);
    in_valid = 1'b1; tick(); in_valid = 1'b0;
    vectors++; if (out_result !== 32'hB) begin miscompares++; $display("FAIL fwd_rs2_sub got %h want 0000000b", out_result); end
    set_op(ADD, 5'd1, 32'h100, 5'd3, 32'h77, 32'd4, 1'b1, 5'd0);
    in_mem_write = 1'b1; in_reg_write = 1'b0;
    in_valid = 1'b1; tick(); in_valid = 1'b0;
    vectors++; if (out_result !== 32'h104 || out_store_data !== 32'h5) begin
      miscompares++; $display("FAIL fwd_store got %h/%h want 00000104/00000005", out_result, out_store_data); end
    vectors++; if (out_mem_write !== 1'b1 || out_reg_write !== 1'b0) begin
      miscompares++; $display("FAIL ctrl_passthru got %b/%b want 1/0", out_mem_write, out_reg_write); end
    fwd_wb_valid = 1'b0;
    tick();
  endtask

  localparam int NALU = 13;
  localparam logic [4:0]  ALU_OP [NALU] = '{SUB, AND_, OR_, XOR_, SLL, SRL, SRA, SLT, SLTU, PASSB, 5'd31, SLT, SLTU};
  localparam logic [31:0] ALU_A  [NALU] = '{32'h5, 32'hF0F0, 32'hF0F0, 32'hFFFF, 32'h1, 32'h80000000, 32'h80000000,
                                            32'hFFFFFFFF, 32'hFFFFFFFF, 32'h9, 32'h5, 32'h3, 32'h3};
  localparam logic [31:0] ALU_B  [NALU] = '{32'h7, 32'hFF00, 32'h0F0F, 32'h0F0F, 32'd33, 32'h4, 32'h4,
                                            32'h0, 32'h0, 32'h1234, 32'h6, 32'hFFFFFFFF, 32'hFFFFFFFF};
  localparam logic [31:0] ALU_X  [NALU] = '{32'hFFFFFFFE, 32'hF000, 32'hFFFF, 32'hF0F0, 32'h2, 32'h08000000, 32'hF8000000,
                                            32'h1, 32'h0, 32'h1234, 32'h0, 32'h0, 32'h1};

  task automatic test_alu();
    for (int i = 0; i < NALU; i++) begin
      set_op(ALU_OP[i], 5'd1, ALU_A[i], 5'd2, ALU_B[i], 32'd0, 1'b0, 5'd4);
      in_valid = 1'b1; tick(); in_valid = 1'b0;
      vectors++; if (out_valid !== 1'b1 || out_result !== ALU_X[i]) begin
        miscompares++; $display("FAIL alu[%0d] op %0d got %b/%h want 1/%h", i, ALU_OP[i], out_valid, out_result, ALU_X[i]); end
    end
    tick();
  endtask

  task automatic test_backpressure();
    set_op(ADD, 5'd1, 32'h10, 5'd0, 32'd0, 32'h20, 1'b1, 5'd3);
    in_valid = 1'b1; out_ready = 1'b0;
    tick();
    set_op(ADD, 5'd1, 32'h1, 5'd0, 32'd0, 32'h2, 1'b1, 5'd4);
    #1;
    vectors++; if (out_valid !== 1'b1 || out_result !== 32'h30) begin miscompares++; $display("FAIL bp_first got %b/%h want 1/00000030", out_valid, out_result); end
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++; if (out_valid !== 1'b1 || out_result !== 32'h30 || out_rd_addr !== 5'd3 || in_ready !== 1'b0) begin
        miscompares++; $display("FAIL bp_hold[%0d] got %b/%h/%h/%b want 1/00000030/03/0", i, out_valid, out_result, out_rd_addr, in_ready); end
    end
    out_ready = 1'b1; #1;
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL bp_release_ready got %b want 1", in_ready); end
    tick(); in_valid = 1'b0;
    vectors++; if (out_valid !== 1'b1 || out_result !== 32'h3 || out_rd_addr !== 5'd4) begin
      miscompares++; $display("FAIL bp_next got %b/%h/%h want 1/00000003/04", out_valid, out_result, out_rd_addr); end
    tick();
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL bp_drain got %b want 0", out_valid); end
  endtask

  localparam int NMD = 12;
  localparam logic [4:0]  MD_OP [NMD] = '{DIV, DIVU, REM, MUL, MULH, MULHU, MULHSU, DIV, REM, REMU, MUL, REM};
  localparam logic [31:0] MD_A  [NMD] = '{32'h80000000, 32'd7, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF,
                                          32'hFFFFFFFF, 32'hFFFFFFF9, 32'hFFFFFFF9, 32'd100, 32'd6, 32'h80000000};
  localparam logic [31:0] MD_B  [NMD] = '{32'hFFFFFFFF, 32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF,
                                          32'hFFFFFFFF, 32'd2, 32'd2, 32'd7, 32'd7, 32'hFFFFFFFF};
  localparam logic [31:0] MD_X  [NMD] = '{32'h80000000, 32'hFFFFFFFF, 32'd7, 32'd1, 32'd0, 32'hFFFFFFFE,
                                          32'hFFFFFFFF, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'd2, 32'd42, 32'd0};

  task automatic test_muldiv();
    int lat, bcnt;
    logic [31:0] res;
    for (int i = 0; i < NMD; i++) begin
      run_md(MD_OP[i], MD_A[i], MD_B[i], lat, bcnt, res);
      vectors++; if (res !== MD_X[i] || out_valid !== 1'b1) begin
        miscompares++; $display("FAIL md[%0d] op %0d got %b/%h want 1/%h", i, MD_OP[i], out_valid, res, MD_X[i]); end
      vectors++; if (lat != 34 || bcnt != 33 || busy !== 1'b0) begin
        miscompares++; $display("FAIL md_lat[%0d] got lat %0d busy %0d/%b want 34/33/0", i, lat, bcnt, busy); end
      if (i == 0) begin
        vectors++; if (out_rd_addr !== 5'd9 || out_reg_write !== 1'b1) begin
          miscompares++; $display("FAIL md_ctrl got %h/%b want 09/1", out_rd_addr, out_reg_write); end
      end
    end
    tick();
  endtask

  task automatic test_flush();
    int late;
    set_op(DIV, 5'd1, 32'd100, 5'd2, 32'd7, 32'd0, 1'b0, 5'd9);
    in_valid = 1'b1; tick(); in_valid = 1'b0;
    repeat (9) tick();
    flush = 1'b1;
    set_op(ADD, 5'd1, 32'd2, 5'd0, 32'd0, 32'd3, 1'b1, 5'd5);
    in_valid = 1'b1; #1;
    vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL flush_ready got %b want 0", in_ready); end
    tick(); flush = 1'b0;
    vectors++; if (busy !== 1'b0 || out_valid !== 1'b0) begin
      miscompares++; $display("FAIL flush_kill got busy %b valid %b want 0/0", busy, out_valid); end
    #1;
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL flush_after_ready got %b want 1", in_ready); end
    tick(); in_valid = 1'b0;
    vectors++; if (out_valid !== 1'b1 || out_result !== 32'd5) begin
      miscompares++; $display("FAIL flush_add got %b/%h want 1/00000005", out_valid, out_result); end
    tick();
    late = 0;
    for (int i = 0; i < 40; i++) begin
      if (out_valid === 1'b1) late++;
      tick();
    end
    vectors++; if (late != 0) begin miscompares++; $display("FAIL flush_stale got %0d valid cycles want 0", late); end
  endtask

  task automatic test_reset_mid();
    int late;
    set_op(MUL, 5'd1, 32'd3, 5'd2, 32'd4, 32'd0, 1'b0, 5'd9);
    in_valid = 1'b1; tick(); in_valid = 1'b0;
    repeat (5) tick();
    vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL rstmid_busy_before got %b want 1", busy); end
    rst = 1'b1; tick();
    vectors++; if (busy !== 1'b0 || out_valid !== 1'b0 || in_ready !== 1'b0) begin
      miscompares++; $display("FAIL rstmid_run got %b/%b/%b want 0/0/0", busy, out_valid, in_ready); end
    rst = 1'b0; #1;
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL rstmid_ready got %b want 1", in_ready); end
    out_ready = 1'b0;
    set_op(ADD, 5'd1, 32'h40, 5'd0, 32'd0, 32'h1, 1'b1, 5'd6);
    in_valid = 1'b1; tick(); in_valid = 1'b0;
    vectors++; if (out_valid !== 1'b1 || out_result !== 32'h41) begin
      miscompares++; $display("FAIL rstmid_load got %b/%h want 1/00000041", out_valid, out_result); end
    rst = 1'b1; tick(); rst = 1'b0;
    vectors++; if (out_valid !== 1'b0 || out_result !== 32'd0 || out_rd_addr !== 5'd0 || out_reg_write !== 1'b0) begin
      miscompares++; $display("FAIL rstmid_slot got %b/%h/%h/%b want 0/0/0/0", out_valid, out_result, out_rd_addr, out_reg_write); end
    out_ready = 1'b1;
    late = 0;
    for (int i = 0; i < 40; i++) begin
      if (out_valid === 1'b1) late++;
      tick();
    end
    vectors++; if (late != 0) begin miscompares++; $display("FAIL rstmid_stale got %0d valid cycles want 0", late); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp;
    in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      set_op(ADD, 5'd1, 32'(i * 16), 5'd0, 32'd0, 32'(i + 1), 1'b1, 5'(i));
      exp = 32'(i * 16 + i + 1);
      tick();
      vectors++; if (out_valid !== 1'b1 || out_result !== exp || out_rd_addr !== 5'(i)) begin
        miscompares++; $display("FAIL b2b[%0d] got %b/%h/%h want 1/%h/%h", i, out_valid, out_result, out_rd_addr, exp, 5'(i)); end
    end
    in_valid = 1'b0;
    tick();
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    set_op(ADD, 5'd0, 32'd0, 5'd0, 32'd0, 32'd0, 1'b0, 5'd0);
    fwd_mem_valid = 1'b0; fwd_wb_valid = 1'b0; fwd_mem_rd = '0; fwd_wb_rd = '0;
    fwd_mem_data = '0; fwd_wb_data = '0;
    test_reset();
    test_forward();
    test_alu();
    test_backpressure();
    test_muldiv();
    test_flush();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
